uart_hex_loader: RTL and testbench
==================================

UART_HEX_LOADER -- requirements
Module: uart_hex_loader

Interface
- Parameters (name, default, meaning):
  - REQ-001 CLKS_PER_BIT, 434, CLK cycles per UART bit (50 MHz / 115200); legal range 4..65535.
- Ports (name, direction, width, meaning):
  - REQ-002 CLK  input  1  sole clock; all state changes on its rising edge.
  - REQ-003 RST_N  input  1  asynchronous, active-low reset.
  - REQ-004 RX  input  1  UART line, 8N1, LSB first, idle high; asynchronous to CLK.
  - REQ-005 DATA  output  16  committed display value; feeds the hex display driver's data input.
  - REQ-006 DATA_VALID  output  1  one-cycle pulse in the cycle DATA takes a new value.
  - REQ-007 FRAME_ERR  output  1  one-cycle pulse when a stop bit samples low.

Function
- REQ-008 RX SHALL pass through a 2-flop synchronizer (reset value 1); all receiver logic SHALL use only the synchronized signal.
- REQ-009 Receiver FSM states SHALL be IDLE, START, DATA, STOP.
- REQ-010 IDLE->START on a synchronized low; the bit counter loads CLKS_PER_BIT/2 (integer division).
- REQ-011 START: at count expiry, line low -> DATA; line high -> IDLE (glitch rejected, no output).
- REQ-012 DATA: 8 samples spaced CLKS_PER_BIT cycles apart, shifted in LSB first, then -> STOP.
- REQ-013 STOP: sample after CLKS_PER_BIT cycles; high -> byte accepted; low -> FRAME_ERR pulse, byte discarded; both -> IDLE in the same cycle.
- REQ-014 An accepted byte SHALL be processed by the parser in the cycle after the stop sample (1-cycle latency).
- REQ-015 Parser state SHALL be a 16-bit shadow register and a 3-bit digit count (0..4).
- REQ-016 Bytes 0x30-0x39, 0x41-0x46 and 0x61-0x66 SHALL map to nibbles 0-9 and A-F; shadow <= {shadow[11:0], nibble}; count increments, saturating at 4 (older digits shift out).
- REQ-017 Byte 0x0D or 0x0A with count>0: DATA <= shadow, DATA_VALID pulses for 1 cycle, shadow <= 0, count <= 0.
- REQ-018 Byte 0x0D or 0x0A with count==0: no change to DATA; no pulse.
- REQ-019 Any other byte SHALL clear shadow and count; DATA is unchanged.
- REQ-020 Fewer than 4 digits SHALL commit zero-extended, e.g. "2A\r" -> DATA=16'h002A.
- REQ-021 DATA SHALL hold its value between commits; DATA_VALID and FRAME_ERR SHALL never assert in the same cycle.

Reset
- REQ-022 RST_N low SHALL immediately force: FSM=IDLE, DATA=16'h0000, DATA_VALID=0, FRAME_ERR=0, shadow=0, count=0, synchronizer=1.
- REQ-023 Reset mid-frame SHALL abandon the frame; after release the receiver SHALL wait for the next high-to-low transition of RX before starting.

Configuration
- REQ-024 Macro UART_HEX_LOADER_AUTOCOMMIT_EN:
  - Defined: on the digit that brings count to 4, DATA <= the new shadow value and DATA_VALID pulses in that same cycle; shadow and count then clear; CR/LF behave per REQ-017/018.
  - Undefined: commits occur only on CR/LF; the 4-digit count saturates per REQ-016.

Verification (CLKS_PER_BIT=8)
- REQ-025 Send "CAFE\r" -> one DATA_VALID pulse; DATA=16'hCAFE; FRAME_ERR never asserts.
- REQ-026 Send "12345\n" -> DATA=16'h2345 (macro undefined); with macro defined -> pulse with DATA=16'h1234 after '4', then "5\n" -> DATA=16'h0005.
- REQ-027 Send byte 0x41 with the stop bit forced low -> FRAME_ERR pulse; shadow and DATA unchanged; next frame "B\r" -> DATA=16'h000B.
- REQ-028 3-cycle low glitch on idle RX -> no state change, no pulses; "beef\r" -> DATA=16'hBEEF.
- REQ-029 "12G3\r" -> DATA=16'h0003; "\r" alone -> no pulse, DATA held.
- REQ-030 Assert RST_N low during DATA bit 4 of a frame, release, send "7\r" -> DATA=16'h0000 during reset; DATA=16'h0007 after the new frame.

Source files
------------

// File: rtl/uart_hex_loader.sv
// UART 8N1 receiver feeding an ASCII-hex parser that commits a 16-bit display value.
// Optional build macro: UART_HEX_LOADER_AUTOCOMMIT_EN (commit on the fourth digit).
module uart_hex_loader #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        RX,
    output logic [15:0] DATA,
    output logic        DATA_VALID,
    output logic        FRAME_ERR
);

    localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] FULL_M1  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_rx_meta;
    logic        r_rx_sync;
    logic [1:0]  r_settle;
    logic        r_armed;
    logic        w_armed_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [2:0]  r_bit;
    logic [2:0]  w_bit_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic        w_expire;
    logic        w_byte_stb;
    logic        w_ferr_stb;
    logic        r_byte_vld;
    logic [7:0]  r_byte;
    logic        r_ferr;

    logic [15:0] r_shadow;
    logic [15:0] w_shadow_nxt;
    logic [2:0]  r_count;
    logic [2:0]  w_count_nxt;
    logic [15:0] r_data;
    logic [15:0] w_data_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic        w_hex;
    logic [3:0]  w_nib;
    logic        w_eol;
    logic [15:0] w_sh_shift;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_settle  <= 2'b00;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
            r_settle  <= {r_settle[0], 1'b1};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_expire = (r_cnt == 16'd0);

    // A start needs the line seen high first, so a reset mid-frame waits for a fresh edge
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_expire ? 16'd0 : r_cnt - 16'd1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_byte_stb  = 1'b0;
        w_ferr_stb  = 1'b0;
        w_armed_nxt = r_armed | (r_settle[1] & r_rx_sync);
        unique case (r_state)
            S_IDLE: begin
                w_bit_nxt = 3'd0;
                if (r_armed && !r_rx_sync) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = HALF_BIT;
                end
            end
            S_START: begin
                if (w_expire) begin
                    if (!r_rx_sync) begin
                        w_state_nxt = S_DATA;
                        w_cnt_nxt   = FULL_M1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (w_expire) begin
                    w_shift_nxt = {r_rx_sync, r_shift[7:1]};
                    w_cnt_nxt   = FULL_M1;
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_expire) begin
                    w_state_nxt = S_IDLE;
                    if (r_rx_sync) begin
                        w_byte_stb = 1'b1;
                    end else begin
                        w_ferr_stb  = 1'b1;
                        w_armed_nxt = 1'b0;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt      <= 16'd0;
            r_bit      <= 3'd0;
            r_shift    <= 8'd0;
            r_armed    <= 1'b0;
            r_byte_vld <= 1'b0;
            r_byte     <= 8'd0;
            r_ferr     <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_bit      <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_armed    <= w_armed_nxt;
            r_byte_vld <= w_byte_stb;
            r_ferr     <= w_ferr_stb;
            if (w_byte_stb) begin
                r_byte <= r_shift;
            end
        end
    end

    always_comb begin
        w_hex = 1'b0;
        w_nib = 4'd0;
        if (r_byte >= 8'h30 && r_byte <= 8'h39) begin
            w_hex = 1'b1;
            w_nib = r_byte[3:0];
        end else if ((r_byte >= 8'h41 && r_byte <= 8'h46) ||
                     (r_byte >= 8'h61 && r_byte <= 8'h66)) begin
            w_hex = 1'b1;
            w_nib = r_byte[3:0] + 4'd9;
        end
    end

    assign w_eol      = (r_byte == 8'h0D) || (r_byte == 8'h0A);
    assign w_sh_shift = {r_shadow[11:0], w_nib};

    always_comb begin
        w_shadow_nxt = r_shadow;
        w_count_nxt  = r_count;
        w_data_nxt   = r_data;
        w_valid_nxt  = 1'b0;
        if (r_byte_vld) begin
            if (w_hex) begin
                w_shadow_nxt = w_sh_shift;
                w_count_nxt  = (r_count == 3'd4) ? 3'd4 : r_count + 3'd1;
`ifdef UART_HEX_LOADER_AUTOCOMMIT_EN
                if (r_count == 3'd3) begin
                    w_data_nxt   = w_sh_shift;
                    w_valid_nxt  = 1'b1;
                    w_shadow_nxt = 16'd0;
                    w_count_nxt  = 3'd0;
                end
`endif
            end else if (w_eol) begin
                if (r_count != 3'd0) begin
                    w_data_nxt   = r_shadow;
                    w_valid_nxt  = 1'b1;
                    w_shadow_nxt = 16'd0;
                    w_count_nxt  = 3'd0;
                end
            end else begin
                w_shadow_nxt = 16'd0;
                w_count_nxt  = 3'd0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_shadow <= 16'd0;
            r_count  <= 3'd0;
            r_data   <= 16'd0;
            r_valid  <= 1'b0;
        end else begin
            r_shadow <= w_shadow_nxt;
            r_count  <= w_count_nxt;
            r_data   <= w_data_nxt;
            r_valid  <= w_valid_nxt;
        end
    end

    assign DATA       = r_data;
    assign DATA_VALID = r_valid;
    assign FRAME_ERR  = r_ferr;

endmodule

// File: tb/tb_uart_hex_loader.sv
// Scoreboard bench for uart_hex_loader at CLKS_PER_BIT=8.
module tb_uart_hex_loader;

    localparam int CPB = 8;

    logic        CLK;
    logic        RST_N;
    logic        RX;
    logic [15:0] DATA;
    logic        DATA_VALID;
    logic        FRAME_ERR;

    int          n_cmp;
    int          n_err;
    logic [15:0] exp_q[$];
    int          fe_exp;

    uart_hex_loader #(.CLKS_PER_BIT(CPB)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .RX        (RX),
        .DATA      (DATA),
        .DATA_VALID(DATA_VALID),
        .FRAME_ERR (FRAME_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge CLK) begin
        if (DATA_VALID && FRAME_ERR) begin
            n_cmp++;
            n_err++;
            $display("FAIL collision: DATA_VALID=1 FRAME_ERR=1, required not both");
        end
        if (DATA_VALID) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_commit: DATA=%h, required no pulse", DATA);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (DATA !== e) begin
                    n_err++;
                    $display("FAIL commit: DATA=%h required %h", DATA, e);
                end
            end
        end
        if (FRAME_ERR) begin
            n_cmp++;
            if (fe_exp == 0) begin
                n_err++;
                $display("FAIL unexpected_frame_err: FRAME_ERR=1 required 0");
            end else begin
                fe_exp--;
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic bit_time(input logic v);
        RX = v;
        repeat (CPB) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop);
        bit_time(1'b1);
        bit_time(1'b1);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || fe_exp != 0) && k < 200) begin
            @(negedge CLK);
            k++;
        end
        check({name, "_commits_left"}, 16'(exp_q.size()), 16'd0);
        check({name, "_ferr_left"}, 16'(fe_exp), 16'd0);
    endtask

    initial begin
        logic [7:0] fb;
        n_cmp  = 0;
        n_err  = 0;
        fe_exp = 0;
        RX     = 1'b1;
        RST_N  = 1'b0;
        repeat (4) @(negedge CLK);
        check("reset_data", DATA, 16'h0000);
        check("reset_valid", {15'd0, DATA_VALID}, 16'd0);
        check("reset_ferr", {15'd0, FRAME_ERR}, 16'd0);
        RST_N = 1'b1;
        repeat (3 * CPB) @(negedge CLK);

        exp_q.push_back(16'hCAFE);
        send_str("CAFE\r");
        drain("cafe");

`ifdef UART_HEX_LOADER_AUTOCOMMIT_EN
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'h0005);
`else
        exp_q.push_back(16'h2345);
`endif
        send_str("12345\n");
        drain("five_digits");

        fe_exp++;
        send_byte(8'h41, 1'b0);
        drain("frame_err");
        check("data_after_ferr", DATA, 16'h2345 ^
`ifdef UART_HEX_LOADER_AUTOCOMMIT_EN
              16'h2340
`else
              16'h0000
`endif
        );
        exp_q.push_back(16'h000B);
        send_str("B\r");
        drain("b_after_ferr");

        RX = 1'b0;
        repeat (3) @(negedge CLK);
        RX = 1'b1;
        repeat (3 * CPB) @(negedge CLK);
        check("data_after_glitch", DATA, 16'h000B);
        exp_q.push_back(16'hBEEF);
        send_str("beef\r");
        drain("beef");

        exp_q.push_back(16'h0003);
        send_str("12G3\r");
        drain("bad_char");
        send_str("\r");
        drain("lone_cr");
        check("data_held_cr", DATA, 16'h0003);

        fb = 8'h41;
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(fb[i]);
        RX = fb[4];
        repeat (CPB / 2) @(negedge CLK);
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        check("data_in_reset", DATA, 16'h0000);
        check("valid_in_reset", {15'd0, DATA_VALID}, 16'd0);
        RST_N = 1'b1;
        bit_time(1'b0);
        repeat (3) bit_time(1'b1);
        check("data_after_reset", DATA, 16'h0000);
        exp_q.push_back(16'h0007);
        send_str("7\r");
        drain("after_reset");
        check("final_data", DATA, 16'h0007);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
